// File: rtl/mem_2p_clr_if.sv
// Port bundle for mem_2p_clr: clear control, write port and read port.
// master drives requests, slave (the RAM) returns busy and read data.
interface mem_2p_clr_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
);
    logic                  clr;
    logic                  busy;
    logic                  we;
    logic [LANES-1:0]      wmask;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output clr, we, wmask, waddr, wdata, re, raddr,
        input  busy, rvalid, rdata
    );

    modport slave (
        input  clr, we, wmask, waddr, wdata, re, raddr,
        output busy, rvalid, rdata
    );
endinterface

// File: rtl/mem_2p_clr.sv
// Simple dual-port RAM with lane write masks, registered read and a clear sweep.
// MEM_BYPASS_EN selects write-first on same-address collisions (default read-first).
module mem_2p_clr #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic         clk,
    input logic         rst,
    mem_2p_clr_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [LANES-1:0]      lane_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    // Read word seen by the port, with optional forwarding of a same-edge write
`ifdef MEM_BYPASS_EN
    logic [DATA_WIDTH-1:0] rd_fwd;
    always_comb begin
        rd_fwd = mem[bus.raddr];
        for (int i = 0; i < LANES; i++) begin
            if (bus.we && bus.wmask[i]) begin
                rd_fwd[i*LANE_WIDTH +: LANE_WIDTH] =
                    bus.wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        rd_word = (bus.waddr == bus.raddr) ? rd_fwd : mem[bus.raddr];
    end
`else
    always_comb begin
        rd_word = mem[bus.raddr];
    end
`endif

    // Next-state, clear sweep pointer, write steering and read capture
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        lane_en   = '0;
        mem_addr  = bus.waddr;
        mem_wdata = bus.wdata;
        unique case (state_q)
            ST_CLEAR: begin
                lane_en   = '1;
                mem_addr  = ptr_q;
                mem_wdata = CLEAR_VALUE;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.we) begin
                    lane_en = bus.wmask;
                end
                if (bus.re) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_word;
                end
                if (bus.clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Control and read-data registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array: lane-masked write from either the port or the sweep
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                mem[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                    mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign bus.busy   = (state_q == ST_CLEAR);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: doc/mem_2p_clr.md
# mem_2p_clr

Parametrised simple dual-port RAM with per-lane write masks, registered read with valid flag, and a hardware clear engine that sweeps every word to a constant after reset or on request. It is the next-generation storage primitive for buffers and tables that need known contents without a software init loop. One write port and one read port share one clock.

## Interface
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 4, bits per write-mask lane; LANES = DATA_WIDTH/LANE_WIDTH
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear engine

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  pulse: start a clear sweep (honoured only when idle)
- busy  out  1  clear sweep in progress; port accesses ignored
- we  in  1  write enable
- wmask  in  LANES  per-lane write enable; bit i covers wdata[i*LANE_WIDTH +: LANE_WIDTH]
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- re  in  1  read enable
- raddr  in  ADDR_WIDTH  read address
- rvalid  out  1  rdata updated this cycle
- rdata  out  DATA_WIDTH  read data, registered

## Operation
- Reset values: busy=1, rvalid=0, rdata=0, clear pointer=0, FSM=CLEAR. Array contents are not reset directly; the sweep defines them.
- FSM states: CLEAR, IDLE.
  - CLEAR: each edge writes CLEAR_VALUE to mem[ptr], ptr increments. On the edge writing ptr=DEPTH-1, go to IDLE, ptr wraps to 0.
  - IDLE: clr=1 on an edge → CLEAR, ptr=0. clr in CLEAR is ignored (no restart).
- busy = (state==CLEAR), combinational from state.
- Write (IDLE only): we=1 → for each lane i with wmask[i]=1, mem[waddr] lane i ← wdata lane i; unmasked lanes keep old value. we=1 with wmask=0 is a no-op.
- Read (IDLE only): re=1 → rdata ← mem[raddr], rvalid=1 next cycle. re=0 → rvalid=0, rdata holds last value.
- While busy: we, re ignored; rvalid=0; rdata holds.
- clr and we/re in the same IDLE cycle: the write and read both take effect; the sweep starts on the same edge and overwrites from address 0.
- rst mid-sweep: sweep restarts from address 0; full DEPTH cycles again.
- Read/write same address same cycle: see Configuration.

## Timing
- Read latency 1 cycle: re sampled at edge N, rdata/rvalid valid after edge N, for one cycle.
- Write visible to a read issued on the following edge.
- Clear sweep: exactly DEPTH edges; busy falls after the DEPTH-th rising edge following rst deassertion or clr acceptance. First accepted access is on edge DEPTH+1.
- Throughput: one read and one write per cycle when idle.

## Configuration
- MEM_BYPASS_EN defined: read and write to the same address on the same edge return the new word, i.e. old data with masked lanes replaced by wdata (write-first).
- Not defined: same-address collision returns the old word (read-first); the write still completes.

## Test plan
- Reset release, DEPTH=256, CLEAR_VALUE=8'hA5 → busy high for exactly 256 edges; then reads of addr 0, 0x7F, 0xFF return 8'hA5, rvalid one cycle after each re.
- Write addr 0x10 data 8'h3C wmask 2'b11, then wmask 2'b01 data 8'hF7 → read 0x10 returns 8'h37.
- Same-edge write 0x20 data 8'h99 mask 2'b11 with read 0x20 holding 8'h11 → rdata 8'h99 with MEM_BYPASS_EN, 8'h11 without; next read 8'h99 in both builds.
- clr pulse after writing 0x05=8'h42; we/re asserted during sweep → writes dropped, rvalid stays 0, busy 256 cycles; afterwards 0x05 reads CLEAR_VALUE.
- rst asserted at sweep cycle 100 for one cycle → busy stays high, another 256 edges counted from release.
- Back-to-back reads 0x00..0x03 with re held high → rvalid high four consecutive cycles, data in order; re low → rvalid 0, rdata holds last word.
